alu_issue_ctrl: RTL

Sequencer that sits in front of the ALU-with-control datapath and drives its `ALUOp` / `OpcodeField` interface. It accepts one LEGv8 instruction plus register operands per handshake and decodes the 11-bit opcode into `ALUOp` and `OpcodeField`. It presents A/B operands for a fixed ALU latency, captures the result and Zero flag, and returns them through a valid/ready response port.

---
 rtl/alu_issue_pkg.sv | 16 +
 rtl/alu_issue_decode.sv | 22 ++
 rtl/alu_issue_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcodes, ALUOp codes, formats and FSM states shared by the ALU issue sequencer.
package alu_issue_pkg;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_NOR  = 11'b11101010000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_CB  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  typedef enum logic [1:0] {FMT_R = 2'd0, FMT_D = 2'd1, FMT_CB = 2'd2} fmt_t;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational LEGv8 opcode decode; ALU_ISSUE_NOR_EN adds NOR as an R-type op.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [1:0]  aluop,
  output fmt_t        fmt,
  output logic        illegal
);
  logic is_r, is_d, is_cb, nor_hit;
`ifdef ALU_ISSUE_NOR_EN
  assign nor_hit = opcode == OP_NOR;
`else
  assign nor_hit = 1'b0;
`endif
  assign is_r = opcode == OP_AND || opcode == OP_ORR || opcode == OP_ADD || opcode == OP_SUB || nor_hit;
  assign is_d = opcode == OP_LDUR || opcode == OP_STUR;
  assign is_cb = opcode[10:3] == OP_CBZ_PFX;
  assign illegal = !(is_r || is_d || is_cb);
  assign aluop = is_r ? ALUOP_R : is_cb ? ALUOP_CB : ALUOP_MEM;
  assign fmt = is_r ? FMT_R : is_cb ? FMT_CB : FMT_D;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one LEGv8 ALU op per handshake, holds operands ALU_LAT cycles, returns result.
// Optional ALU_ISSUE_NOR_EN macro enables NOR decode.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rn_data,
  input  logic [DATA_W-1:0] rm_data,
  output logic [1:0]        ALUOp,
  output logic [10:0]       OpcodeField,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic              res_illegal
);
  state_t state, state_n;
  logic [3:0] cnt;
  logic [1:0] dec_aluop;
  fmt_t dec_fmt;
  logic dec_illegal, accept, done, unused_bits;
  logic [DATA_W-1:0] d_off;
  alu_issue_decode u_dec (
    .opcode (instr[31:21]),
    .aluop  (dec_aluop),
    .fmt    (dec_fmt),
    .illegal(dec_illegal)
  );
  assign instr_ready = state == IDLE;
  assign res_valid = state == RESP;
  assign accept = instr_ready && instr_valid;
  assign done = state == EXEC && cnt == 4'd1;
  assign d_off = {{(DATA_W-9){instr[20]}}, instr[20:12]};
  assign unused_bits = ^instr[11:0];
  always_comb
    state_n = accept ? (dec_illegal ? RESP : EXEC) : done ? RESP : (res_valid && res_ready) ? IDLE : state;
  // Illegal ops skip EXEC and leave the ALU-side registers untouched.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ALUOp <= '0;
      OpcodeField <= '0;
      A <= '0;
      B <= '0;
      res_data <= '0;
      res_zero <= 1'b0;
      res_illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && !dec_illegal) begin
        cnt <= 4'(ALU_LAT);
        ALUOp <= dec_aluop;
        OpcodeField <= instr[31:21];
        A <= dec_fmt == FMT_CB ? '0 : rn_data;
        B <= dec_fmt == FMT_D ? d_off : rm_data;
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
      end
      if (accept && dec_illegal) begin
        res_data <= '0;
        res_zero <= 1'b0;
        res_illegal <= 1'b1;
      end else if (done) begin
        res_data <= alu_result;
        res_zero <= alu_zero;
        res_illegal <= 1'b0;
      end
    end
endmodule
